// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle for mem_arbiter.
// "slave" is the arbiter's view; "master" is the caches plus RAM as seen by the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dwait;
  logic [ADDR_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache requests onto a single-ported RAM.
// Data wins by default; a saturating starvation counter forces an instruction grant.
module mem_arbiter #(
  parameter int ISTARVE_MAX = 4,
  parameter int ADDR_W      = 32
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] RS_ACCESS  = 2'd2;
  localparam logic [3:0] STARVE_MAX = 4'(ISTARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic d_req;
  logic i_force;
  logic ram_access;

  assign d_req      = bus.dREN | bus.dWEN;
  assign ram_access = (bus.ramstate == RS_ACCESS);
  assign i_force    = bus.iREN && (starve_cnt_q == STARVE_MAX);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (d_req && !i_force) begin
          state_d = DGRANT;
          if (bus.iREN && (starve_cnt_q != STARVE_MAX))
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (bus.iREN) begin
          state_d      = IGRANT;
          starve_cnt_d = '0;
        end
      end
      // A dropped request abandons the grant without signalling completion.
      IGRANT: if (!bus.iREN || ram_access) state_d = IDLE;
      DGRANT: if (!d_req || ram_access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Outputs are combinational so completion lands in the ACCESS cycle itself.
  always_comb begin
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      IGRANT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        if (ram_access && bus.iREN) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      DGRANT: begin
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (ram_access && d_req) begin
          bus.dwait = 1'b0;
          if (bus.dREN) bus.dload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued when a grant's
// ACCESS cycle is driven and popped by a monitor when iwait/dwait go low.
module tb_mem_arbiter;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic nrst;
  int   total;
  int   bad;
  exp_t sb[$];
  exp_t mon_e;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ISTARVE_MAX(4), .ADDR_W(32)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  // One IDLE cycle, then a grant whose first cycle returns ACCESS.
  task automatic do_grant(input bit exp_d, input logic [31:0] ld,
                          input logic [31:0] exp_data, input logic [31:0] exp_addr);
    bus.ramstate = RS_FREE;
    to_neg();
    chk("idle_ren", {31'b0, bus.ramREN}, 32'd0);
    chk("idle_wen", {31'b0, bus.ramWEN}, 32'd0);
    to_pos();
    bus.ramstate = RS_ACCESS;
    bus.ramload  = ld;
    push_exp(exp_d, exp_data);
    to_neg();
    chk("grant_addr", bus.ramaddr, exp_addr);
    to_pos();
  endtask

  always @(negedge clk) begin
    if (nrst === 1'b1 && (bus.iwait === 1'b0 || bus.dwait === 1'b0)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_side", {31'b0, ~bus.dwait}, {31'b0, mon_e.is_d});
        chk("sb_data", (bus.dwait === 1'b0) ? bus.dload : bus.iload, mon_e.data);
        chk("sb_both", {31'b0, bus.iwait | bus.dwait}, 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    nrst  = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b0; bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
    bus.ramstate = RS_ACCESS; bus.ramload = 32'hFFFF;

    // Reset: outputs idle regardless of inputs
    to_neg();
    chk("rst_iwait", {31'b0, bus.iwait}, 32'd1);
    chk("rst_dwait", {31'b0, bus.dwait}, 32'd1);
    chk("rst_iload", bus.iload, 32'd0);
    chk("rst_dload", bus.dload, 32'd0);
    chk("rst_ren", {31'b0, bus.ramREN}, 32'd0);
    chk("rst_wen", {31'b0, bus.ramWEN}, 32'd0);
    chk("rst_addr", bus.ramaddr, 32'd0);
    chk("rst_store", bus.ramstore, 32'd0);
    to_pos();
    nrst = 1'b1;
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramstate = RS_FREE; bus.ramload = '0;
    to_pos();

    // 1: single instruction fetch, ACCESS on the 3rd cycle
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    to_neg();
    chk("t1_idle_ren", {31'b0, bus.ramREN}, 32'd0);
    to_pos();
    bus.ramstate = RS_BUSY;
    to_neg();
    chk("t1_ren", {31'b0, bus.ramREN}, 32'd1);
    chk("t1_addr", bus.ramaddr, 32'h40);
    chk("t1_iwait_busy", {31'b0, bus.iwait}, 32'd1);
    to_pos();
    bus.ramstate = RS_ACCESS; bus.ramload = 32'h2108FFFF;
    push_exp(1'b0, 32'h2108FFFF);
    to_neg();
    to_pos();
    bus.iREN = 1'b0; bus.ramstate = RS_FREE;
    to_neg();
    chk("t1_after_ren", {31'b0, bus.ramREN}, 32'd0);
    chk("t1_after_iwait", {31'b0, bus.iwait}, 32'd1);
    to_pos();

    // 2: simultaneous iREN and dWEN, data first
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF;
    to_neg();
    chk("t2_idle_wen", {31'b0, bus.ramWEN}, 32'd0);
    to_pos();
    bus.ramstate = RS_ACCESS; bus.ramload = 32'h5555AAAA;
    push_exp(1'b1, 32'h0);
    to_neg();
    chk("t2_wen", {31'b0, bus.ramWEN}, 32'd1);
    chk("t2_ren", {31'b0, bus.ramREN}, 32'd0);
    chk("t2_store", bus.ramstore, 32'hDEADBEEF);
    chk("t2_addr", bus.ramaddr, 32'h80);
    chk("t2_iwait", {31'b0, bus.iwait}, 32'd1);
    to_pos();
    bus.dWEN = 1'b0;
    do_grant(1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h44);
    bus.iREN = 1'b0;

    // 3: fairness with iREN held and data re-requested continuously
    bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.dREN = 1'b1;
    for (int k = 0; k < 11; k++) begin
      bit          is_i;
      logic [31:0] ld;
      is_i = (k == 4) || (k == 9);
      ld   = 32'hC0DE0000 + 32'(k);
      bus.daddr = 32'h1000 + 32'(k * 4);
      do_grant(!is_i, ld, ld, is_i ? 32'h100 : bus.daddr);
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;

    // 4: ERROR held off, then ACCESS
    bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = RS_FREE;
    to_neg();
    to_pos();
    for (int k = 0; k < 3; k++) begin
      bus.ramstate = RS_ERROR; bus.ramload = 32'hEEEE0000 + 32'(k);
      to_neg();
      chk("t4_dwait_err", {31'b0, bus.dwait}, 32'd1);
      chk("t4_ren_err", {31'b0, bus.ramREN}, 32'd1);
      to_pos();
    end
    bus.ramstate = RS_ACCESS; bus.ramload = 32'h12345678;
    push_exp(1'b1, 32'h12345678);
    to_neg();
    to_pos();
    bus.dREN = 1'b0; bus.ramstate = RS_FREE;

    // 5: iREN dropped mid-grant
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    to_neg();
    to_pos();
    bus.ramstate = RS_BUSY;
    to_neg();
    chk("t5_ren", {31'b0, bus.ramREN}, 32'd1);
    to_pos();
    bus.iREN = 1'b0;
    to_neg();
    chk("t5_drop_ren", {31'b0, bus.ramREN}, 32'd0);
    chk("t5_drop_iwait", {31'b0, bus.iwait}, 32'd1);
    to_pos();
    bus.iREN = 1'b1; bus.ramstate = RS_ACCESS; bus.ramload = 32'hBAD0BAD0;
    to_neg();
    chk("t5_idle_ren", {31'b0, bus.ramREN}, 32'd0);
    to_pos();
    bus.ramload = 32'h0BADF00D;
    push_exp(1'b0, 32'h0BADF00D);
    to_neg();
    chk("t5_regrant_addr", bus.ramaddr, 32'h300);
    to_pos();
    bus.iREN = 1'b0; bus.ramstate = RS_FREE;

    // 6: reset mid-DGRANT with the starvation counter at its limit
    bus.iREN = 1'b1; bus.iaddr = 32'h500;
    bus.dWEN = 1'b1; bus.daddr = 32'h600; bus.dstore = 32'hFEEDFACE;
    for (int k = 0; k < 3; k++) do_grant(1'b1, 32'h9999, 32'h0, 32'h600);
    bus.ramstate = RS_FREE;
    to_neg();
    to_pos();
    bus.ramstate = RS_BUSY;
    to_neg();
    chk("t6_wen", {31'b0, bus.ramWEN}, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6_rst_wen", {31'b0, bus.ramWEN}, 32'd0);
    chk("t6_rst_ren", {31'b0, bus.ramREN}, 32'd0);
    chk("t6_rst_dwait", {31'b0, bus.dwait}, 32'd1);
    chk("t6_rst_addr", bus.ramaddr, 32'd0);
    to_pos();
    nrst = 1'b1; bus.ramstate = RS_FREE;
    do_grant(1'b1, 32'h4444, 32'h0, 32'h600);
    bus.dWEN = 1'b0;
    do_grant(1'b0, 32'h77778888, 32'h77778888, 32'h500);
    bus.iREN = 1'b0; bus.ramstate = RS_FREE;

    to_neg();
    to_pos();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and data cache, between their cache-side memory interfaces and the single-ported RAM.
- Serializes instruction-fetch and data read/write requests onto the RAM interface using a registered grant FSM.
- Returns wait/load handshakes to each cache.
- Data requests have priority; a bounded fairness counter prevents instruction starvation.

Parameters:
- ISTARVE_MAX, 4: consecutive data grants allowed while an instruction request is pending before the instruction side is forced to win the next arbitration. Legal range 1..15.
- ADDR_W, 32: address/data width.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  icache read request
- iaddr  input  ADDR_W  icache word address
- iwait  output  1  high = icache request not complete
- iload  output  ADDR_W  instruction word, valid when iwait=0
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request (dREN and dWEN are never both high)
- daddr  input  ADDR_W  dcache address
- dstore  input  ADDR_W  dcache write data
- dwait  output  1  high = dcache request not complete
- dload  output  ADDR_W  data word, valid when dwait=0 and dREN
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  ADDR_W  RAM address
- ramstore  output  ADDR_W  RAM write data
- ramload  input  ADDR_W  RAM read data
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE, starve_cnt=0.
  - Outputs during reset: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- States: IDLE, IGRANT, DGRANT. State and starve_cnt are registered; all outputs are combinational from state and inputs.
- IDLE:
  - RAM strobes low; iwait=dwait=1.
  - Next state:
    - DGRANT if (dREN|dWEN) and not (iREN and starve_cnt==ISTARVE_MAX).
    - Else IGRANT if iREN.
    - Else IDLE.
- IGRANT:
  - ramREN=iREN, ramWEN=0, ramaddr=iaddr; dwait=1.
  - When ramstate==ACCESS and iREN: iwait=0 and iload=ramload for exactly that cycle; next state IDLE.
  - Otherwise iwait=1 and iload=0.
  - If iREN drops while in IGRANT: next state IDLE, no completion is signalled.
- DGRANT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; iwait=1.
  - When ramstate==ACCESS and (dREN|dWEN): dwait=0, dload=ramload (reads only, else 0); next state IDLE.
  - If both dREN and dWEN drop: next state IDLE, no completion.
- ramstate BUSY, FREE or ERROR while granted: hold the grant with wait=1. ERROR is never reported as completion.
- Latency:
  - Minimum 2 cycles from request to completion: IDLE→grant edge, then the ACCESS cycle.
  - Back-to-back requests cost one IDLE cycle between them.
- starve_cnt:
  - Increments (saturating at ISTARVE_MAX) on each IDLE→DGRANT transition taken while iREN=1.
  - Clears to 0 on IDLE→IGRANT.
  - Unchanged otherwise.
- Simultaneous iREN and dREN in IDLE with starve_cnt<ISTARVE_MAX: data wins.
- Request address or data changing mid-grant is passed straight through to the RAM; the arbiter does not latch it. Caches hold requests stable until wait=0.
- Reset asserted mid-grant: returns to IDLE immediately; the in-flight RAM access is abandoned and strobes drop asynchronously.

Test Plan:
1. Reset then iREN=1, iaddr=0x40, RAM returns ACCESS on the 3rd cycle with ramload=0x2108FFFF → ramREN high with ramaddr=0x40 from the cycle after the request; iwait=0 and iload=0x2108FFFF for exactly one cycle; then IDLE.
2. iREN and dWEN both asserted in the same IDLE cycle, daddr=0x80, dstore=0xDEADBEEF → DGRANT first with ramWEN=1 and ramstore=0xDEADBEEF; dwait pulses low on ACCESS; one IDLE cycle, then IGRANT serves the instruction fetch.
3. iREN held high while dREN is re-asserted continuously, ISTARVE_MAX=4, ACCESS returned every grant → exactly 4 data completions, then 1 instruction completion, then starve_cnt=0 and data resumes.
4. In DGRANT, ramstate=ERROR for 3 cycles, then ACCESS with ramload=0x12345678 → dwait stays 1 through the ERROR cycles; dload=0x12345678 with dwait=0 on the ACCESS cycle.
5. In IGRANT, iREN dropped before ACCESS → next cycle IDLE, iwait never low, ramREN low.
6. nRST pulsed low mid-DGRANT → ramWEN/ramREN drop to 0 in the same cycle, state IDLE, starve_cnt=0; a subsequent iREN is serviced normally.
